pong_match_ctrl: RTL
====================

// Module: pong_match_ctrl
// PURPOSE
//  Parametrised match controller for the pong game. Sits between the logic-rate
//  blocks (barra/ball) and the graphics layer.
//  - Owns scores, serve timing, pause handling, win-by-two rule and game-over.
//  - Gates the ball through ball_run/ball_reset. Supersedes the fixed 3-bit
//    scores block.
// PARAMETERS
//  SCORE_W      4    score counter width; scores saturate at 2^SCORE_W-1
//  WIN_SCORE    7    points needed to win; must be < 2^SCORE_W-1
//  WIN_BY_TWO   1    1: winner must also lead by >=2; 0: first to WIN_SCORE
//  SERVE_TICKS  120  ticks ball held centred before each rally (>=1)
//  POINT_TICKS  60   ticks of post-point freeze (>=1)
//  TMR_W        8    timer width; must hold max(SERVE_TICKS,POINT_TICKS)
// PORTS
//  mclk        in   1        system clock; all logic on posedge
//  reset_n     in   1        synchronous reset, active-low
//  tick        in   1        1-cycle logic-rate enable pulse (from Sha)
//  pause       in   1        level; freezes timers and ball
//  start       in   1        level/pulse; starts a match from IDLE or OVER
//  point1      in   1        P1 scored (from ball), sampled every mclk
//  point2      in   1        P2 scored
//  score1      out  SCORE_W  P1 score
//  score2      out  SCORE_W  P2 score
//  ball_run    out  1        ball logic may advance
//  ball_reset  out  1        hold ball at centre
//  serve_dir   out  1        0: serve toward P1, 1: serve toward P2
//  playing     out  1        0 only in OVER
//  winner      out  1        1: P1 won; valid while playing=0
//  state       out  3        IDLE=0 SERVE=1 RALLY=2 POINT=3 OVER=4
// BEHAVIOUR
//  - All outputs are registered. Inputs sampled at edge n appear at n+1.
//  - Reset (reset_n=0 at an edge), from any state, mid-timer included:
//    state=IDLE, scores=0, timer=0, ball_run=0, ball_reset=1, serve_dir=0,
//    playing=1, winner=0.
//  - ball_reset = 1 in IDLE, SERVE, POINT and OVER.
//  - ball_run = 1 only when state is RALLY and pause=0.
//  - Timer advancement: the timer counts only on cycles with tick=1 and pause=0.
//  - IDLE: start=1 -> SERVE; scores:=0, timer:=0.
//  - SERVE: on the SERVE_TICKS-th counted tick -> RALLY; timer:=0.
//  - RALLY, pause=0, point events:
//    - point1 only: score1+1; serve_dir:=1; -> POINT.
//    - point2 only: score2+1; serve_dir:=0; -> POINT.
//    - point1 and point2 together: let. No score change, serve_dir unchanged,
//      -> POINT.
//  - RALLY, pause=1: points are ignored.
//  - Points in any state other than RALLY are ignored.
//  - Win check, evaluated on the new scores at the scoring edge, into a
//    registered match_done flag:
//    - Win when the scorer has >=WIN_SCORE and (WIN_BY_TWO=0 or lead>=2).
//    - Saturation: if an increment would reach 2^SCORE_W-1, the scorer wins
//      regardless of lead. No wrap ever.
//  - POINT: on the POINT_TICKS-th counted tick:
//    - match_done=1 -> OVER; playing:=0; winner:=(score1>score2).
//    - otherwise -> SERVE; timer:=0.
//  - OVER: scores held. start=1 -> SERVE; scores:=0, match_done:=0,
//    playing:=1, serve_dir toggled (loser did not serve last).
//  - start is ignored in SERVE, RALLY and POINT.
//  - tick and point on the same edge: the point is processed and the timer
//    restarts at 0.
// TESTING
//  - Reset: hold reset_n=0 for 2 cycles mid-RALLY with score1=3 -> next edge
//    state=0, score1=0, ball_reset=1, ball_run=0.
//  - Serve delay: SERVE_TICKS=4, start then 4 ticks -> state=2 one cycle after
//    the 4th tick; a tick with pause=1 does not count.
//  - Scoring: point1 pulse in RALLY -> next cycle score1=1, serve_dir=1,
//    state=3. Both points together -> scores unchanged, state=3.
//  - Win-by-two: WIN_SCORE=7, scores 6-6, P1 scores -> 7-6, no win. P1 scores
//    again -> 8-6; after POINT_TICKS, state=4, playing=0, winner=1.
//  - Saturation: SCORE_W=3, WIN_SCORE=5, alternate points up to 6-6, P2
//    scores -> score2=7, winner=0, no wrap.
//  - Ignored events: point2 during POINT/SERVE/OVER and start during RALLY ->
//    no score or state change. start in OVER -> SERVE, scores 0-0.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match controller owning scores, serve/point timing, pause, win-by-two and game-over
module pong_match_ctrl #(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 7,
    parameter int WIN_BY_TWO  = 1,
    parameter int SERVE_TICKS = 120,
    parameter int POINT_TICKS = 60,
    parameter int TMR_W       = 8
) (
    input  logic               mclk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               pause,
    input  logic               start,
    input  logic               point1,
    input  logic               point2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               ball_run,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic               playing,
    output logic               winner,
    output logic [2:0]         state
);
    typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, RALLY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
    localparam logic [SCORE_W:0]   MAX_X      = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [SCORE_W:0]   WIN_X      = (SCORE_W+1)'(WIN_SCORE);
    localparam logic [TMR_W-1:0]   SERVE_LAST = TMR_W'(SERVE_TICKS - 1);
    localparam logic [TMR_W-1:0]   POINT_LAST = TMR_W'(POINT_TICKS - 1);
    state_t             state_q, state_d;
    logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               done_q, done_d, dir_q, dir_d, play_q, play_d, win_q, win_d;
    logic               run_q, run_d, hold_q, hold_d;
    logic               cnt, win1, win2;
    logic [SCORE_W:0]   inc1, inc2;
    // next-state, score and win evaluation; a scorer reaching the saturation value wins outright
    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        tmr_d   = tmr_q;
        done_d  = done_q;
        dir_d   = dir_q;
        play_d  = play_q;
        win_d   = win_q;
        cnt     = tick && !pause;
        inc1    = {1'b0, s1_q} + (SCORE_W+1)'(1);
        inc2    = {1'b0, s2_q} + (SCORE_W+1)'(1);
        win1    = (inc1 >= MAX_X) || (inc1 >= WIN_X && (WIN_BY_TWO == 0 || inc1 >= {1'b0, s2_q} + (SCORE_W+1)'(2)));
        win2    = (inc2 >= MAX_X) || (inc2 >= WIN_X && (WIN_BY_TWO == 0 || inc2 >= {1'b0, s1_q} + (SCORE_W+1)'(2)));
        case (state_q)
            IDLE: if (start) begin
                state_d = SERVE;
                s1_d    = '0;
                s2_d    = '0;
                tmr_d   = '0;
            end
            SERVE: if (cnt) begin
                state_d = (tmr_q == SERVE_LAST) ? RALLY : SERVE;
                tmr_d   = (tmr_q == SERVE_LAST) ? '0 : tmr_q + TMR_W'(1);
            end
            RALLY: if (!pause && (point1 || point2)) begin
                state_d = POINT;
                tmr_d   = '0;
                if (point1 && !point2) begin
                    s1_d   = (inc1 > MAX_X) ? s1_q : inc1[SCORE_W-1:0];
                    dir_d  = 1'b1;
                    done_d = win1;
                end
                if (point2 && !point1) begin
                    s2_d   = (inc2 > MAX_X) ? s2_q : inc2[SCORE_W-1:0];
                    dir_d  = 1'b0;
                    done_d = win2;
                end
            end
            POINT: if (cnt) begin
                tmr_d = (tmr_q == POINT_LAST) ? '0 : tmr_q + TMR_W'(1);
                if (tmr_q == POINT_LAST) begin
                    state_d = done_q ? OVER : SERVE;
                    play_d  = !done_q;
                    win_d   = done_q ? (s1_q > s2_q) : win_q;
                end
            end
            OVER: if (start) begin
                state_d = SERVE;
                s1_d    = '0;
                s2_d    = '0;
                tmr_d   = '0;
                done_d  = 1'b0;
                play_d  = 1'b1;
                dir_d   = !dir_q;
            end
            default: state_d = IDLE;
        endcase
        run_d  = (state_d == RALLY) && !pause;
        hold_d = (state_d != RALLY);
    end
    // register all state and outputs; reset_n low returns everything to the idle values
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            tmr_q   <= '0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            play_q  <= 1'b1;
            win_q   <= 1'b0;
            run_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
            play_q  <= play_d;
            win_q   <= win_d;
            run_q   <= run_d;
            hold_q  <= hold_d;
        end
    end
    assign score1     = s1_q;
    assign score2     = s2_q;
    assign ball_run   = run_q;
    assign ball_reset = hold_q;
    assign serve_dir  = dir_q;
    assign playing    = play_q;
    assign winner     = win_q;
    assign state      = state_q;
endmodule
